sng_stream: RTL and testbench
=============================

SNG_STREAM -- requirements
Module: sng_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and comparison width in bits.
REQ-002 SHALL have parameter LEN_LOG2, default 8: stream length N = 2^LEN_LOG2 bits per operand.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_value  input  WIDTH  unsigned operand to encode.
REQ-008 SHALL have port rand_in  input  32  random value from the upstream LFSR countval; only bits [WIDTH-1:0] are used.
REQ-009 SHALL have port rand_en  output  1  advance enable driven to the LFSR en input.
REQ-010 SHALL have port bit_valid  output  1  bit_out is valid this cycle.
REQ-011 SHALL have port bit_out  output  1  stochastic bitstream bit.
REQ-012 SHALL have port last  output  1  marks the final bit of the stream, coincident with bit_valid.
REQ-013 SHALL have port ones_cnt  output  LEN_LOG2+1  count of ones emitted in the current stream.

Function
REQ-014 SHALL implement states IDLE, PRIME and RUN, plus a counter cnt of LEN_LOG2 bits.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid=1 it SHALL register in_value into op, clear cnt and go to PRIME.
REQ-016 In PRIME and RUN, in_ready SHALL be 0; in_valid SHALL be ignored and op SHALL NOT change.
REQ-017 PRIME SHALL last exactly 2 cycles, covering the LFSR register plus countval latency; rand_en=1 and no bits are emitted.
REQ-018 RUN SHALL last exactly N cycles; rand_en=1 and cnt increments each cycle.
REQ-019 In each RUN cycle, the edge ending it SHALL set bit_out <= (rand_in[WIDTH-1:0] < op), unsigned strict less-than, and bit_valid <= 1.
REQ-020 The same edge SHALL set last <= (cnt == N-1).
REQ-021 After the RUN cycle with cnt == N-1 the block SHALL go to IDLE; cnt wraps to 0 and is not reused.
REQ-022 rand_en SHALL be 0 in IDLE, so the LFSR holds between streams.
REQ-023 bit_valid and last SHALL be 0 in every cycle not immediately following a RUN cycle.
REQ-024 bit_out SHALL hold its last value when bit_valid=0.
REQ-025 There is no downstream backpressure; every emitted bit must be consumed in the cycle it is valid.
REQ-026 Latency: for an accept edge at the end of cycle 0, the first bit_valid SHALL be in cycle 4 and last in cycle 3+N.
REQ-027 in_ready SHALL be 1 in cycle 3+N, allowing back-to-back streams with no gap cycle.
REQ-028 op=0 SHALL yield all zeros.
REQ-029 The comparison SHALL NOT saturate: op=2^WIDTH-1 yields zero for rand values equal to 2^WIDTH-1.

Reset
REQ-030 rst=1 SHALL, asynchronously, force state to IDLE and clear op, cnt and ones_cnt.
REQ-031 rst=1 SHALL, asynchronously, force rand_en, bit_valid, bit_out and last to 0.
REQ-032 While rst=1, in_ready SHALL be 1.
REQ-033 Reset during PRIME or RUN SHALL abandon the stream; no further bits SHALL be emitted and no partial last SHALL be produced.
REQ-034 The first cycle after rst deasserts SHALL accept in_valid normally.

Configuration
REQ-035 Macro SNG_ONES_COUNT_EN SHALL control the ones counter.
REQ-036 With SNG_ONES_COUNT_EN defined, ones_cnt SHALL clear on operand accept and increment on each edge that sets bit_out=1 with bit_valid=1.
REQ-037 With SNG_ONES_COUNT_EN defined, ones_cnt SHALL be final and stable from the cycle where last=1 until the next accept.
REQ-038 With SNG_ONES_COUNT_EN undefined, ones_cnt SHALL be constant 0, with no counter logic; the port list SHALL be unchanged.

Verification (WIDTH=16, LEN_LOG2=4, N=16)
REQ-039 Reset: assert rst mid-clock -> all outputs 0 and in_ready=1 immediately; release -> accept is possible in the next cycle.
REQ-040 op=0x0000 with a free-running lfsr16 (FLAVOR=0) -> 16 bit_valid pulses in cycles 4..19, all bit_out=0, last only in cycle 19, ones_cnt=0 (macro on).
REQ-041 rand_in held at 0xFFFF0100, op=0x0101 -> 16 ones, which shows the upper bits are ignored; ones_cnt=16 with the macro, 0 without it.
REQ-042 in_valid held high for 40 cycles with values 0x8000 then 0x0000 -> second accept in cycle 19 and its first bit in cycle 23; in_valid during RUN does not alter the first stream.
REQ-043 rst pulsed after the 5th bit_valid -> bit_valid and last drop immediately; no last seen; the next stream runs a full 16 bits.
REQ-044 op=0x8000 with lfsr16 -> rand_en high in exactly 18 cycles per stream; ones_cnt equals a reference-model count of (rand<0x8000) over the sampled values.

Source files
------------

// File: rtl/sng_stream.sv
// -----------------------------------------------------------------------------
// sng_stream
//   Stochastic number generator: encodes one unsigned operand as an N-bit
//   stochastic bitstream (N = 2**LEN_LOG2). Each output bit is 1 when the
//   upstream LFSR sample is strictly below the operand.
//
//   Build option:
//     SNG_ONES_COUNT_EN : when defined, ones_cnt counts the ones emitted in the
//                         current stream. When undefined, ones_cnt is tied to
//                         0 and no counter exists.
//
//   Ports:
//     clk        in   clock, all state updates on the rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   operand offered
//     in_ready   out  block can accept an operand (IDLE only)
//     in_value   in   [WIDTH-1:0] operand to encode
//     rand_in    in   [31:0] LFSR countval, only [WIDTH-1:0] used
//     rand_en    out  LFSR advance enable (PRIME and RUN)
//     bit_valid  out  bit_out valid this cycle
//     bit_out    out  stochastic bit, holds while bit_valid=0
//     last       out  final bit of the stream, coincident with bit_valid
//     ones_cnt   out  [LEN_LOG2:0] ones emitted in the current stream
// -----------------------------------------------------------------------------
module sng_stream #(
    parameter int WIDTH    = 16,
    parameter int LEN_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_value,
    input  logic [31:0]         rand_in,
    output logic                rand_en,
    output logic                bit_valid,
    output logic                bit_out,
    output logic                last,
    output logic [LEN_LOG2:0]   ones_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [LEN_LOG2-1:0] C_CNT_LAST = '1;
    localparam logic [LEN_LOG2-1:0] C_CNT_ONE  = {{(LEN_LOG2-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH-1:0]       r_op;
    logic [LEN_LOG2-1:0]    r_cnt;
    logic                   r_prime;    // 0 in first PRIME cycle, 1 in second
    logic                   r_bit_valid;
    logic                   r_bit_out;
    logic                   r_last;
    logic                   w_accept;
    logic                   w_hit;
    logic                   w_in_ready;
    logic                   w_rand_en;

    if (WIDTH < 32) begin : g_rand_hi
        logic w_unused_rand_hi;
        assign w_unused_rand_hi = ^rand_in[31:WIDTH];
    end

    // Strict unsigned compare: op = all-ones never matches rand = all-ones.
    assign w_hit    = (rand_in[WIDTH-1:0] < r_op);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake/enable outputs
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_rand_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_PRIME;
                end
            end
            S_PRIME: begin
                w_rand_en = 1'b1;
                if (r_prime) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_rand_en = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand, counters and bit outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= '0;
            r_cnt       <= '0;
            r_prime     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_bit_valid <= (r_state == S_RUN);
            r_last      <= (r_state == S_RUN) && (r_cnt == C_CNT_LAST);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= in_value;
                        r_cnt   <= '0;
                        r_prime <= 1'b0;
                    end
                end
                S_PRIME: begin
                    r_prime <= 1'b1;
                end
                S_RUN: begin
                    r_cnt     <= r_cnt + C_CNT_ONE;
                    r_bit_out <= w_hit;
                end
                default: begin
                    r_prime <= 1'b0;
                end
            endcase
        end
    end

`ifdef SNG_ONES_COUNT_EN
    localparam logic [LEN_LOG2:0] C_ONES_ONE = {{LEN_LOG2{1'b0}}, 1'b1};
    logic [LEN_LOG2:0] r_ones;

    // Counts on the same edge that emits a 1, so the value is final while last=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= '0;
        end else if (w_accept) begin
            r_ones <= '0;
        end else if ((r_state == S_RUN) && w_hit) begin
            r_ones <= r_ones + C_ONES_ONE;
        end
    end

    assign ones_cnt = r_ones;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign ones_cnt = '0;
`endif

    assign in_ready  = w_in_ready;
    assign rand_en   = w_rand_en;
    assign bit_valid = r_bit_valid;
    assign bit_out   = r_bit_out;
    assign last      = r_last;

endmodule

// File: tb/tb_sng_stream.sv
// -----------------------------------------------------------------------------
// tb_sng_stream
//   Self-checking bench for sng_stream (WIDTH=16, LEN_LOG2=4, N=16).
//   A timeline model predicts every output from the accept cycle of the
//   current stream and the recorded rand_in history; directed tests pin the
//   model with hand-computed literal expectations.
//   Define SNG_ONES_COUNT_EN for both bench and RTL to test the ones counter.
// -----------------------------------------------------------------------------
module tb_sng_stream;

    localparam int W  = 16;
    localparam int LL = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_value = '0;
    logic [31:0]   rand_in = '0;
    logic          rand_en;
    logic          bit_valid;
    logic          bit_out;
    logic          last;
    logic [LL:0]   ones_cnt;

    sng_stream #(
        .WIDTH    (W),
        .LEN_LOG2 (LL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .rand_in   (rand_in),
        .rand_en   (rand_en),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .last      (last),
        .ones_cnt  (ones_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- upstream LFSR (stimulus source) ----------------
    logic        adv = 1'b0;
    logic [15:0] lfsr = 16'hACE1;
    int          rand_mode = 0;
    logic [31:0] rand_fix = '0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        #1;
        if (adv) lfsr = lfsr_step(lfsr);
        rand_in = (rand_mode != 0) ? rand_fix : {16'h0000, lfsr};
    end

    // ---------------- model + monitor + per-cycle compare ----------------
    logic [31:0] rhist [1024];
    bit          have_acc = 1'b0;
    int          acc_cyc  = 0;
    logic [15:0] op_m     = '0;
    logic        last_bit = 1'b0;
    int          ones_m   = 0;
    int          d;
    bit          busy, vexp, bexp;
    int          exp_ones;

    int rise_q[$];
    int last_q[$];
    int vcnt_tot = 0;
    int ones_tot = 0;
    int re_tot   = 0;
    bit prev_v   = 1'b0;

    always @(negedge clk) begin
        rhist[cyc % 1024] = rand_in;
        adv = rand_en;

        if (bit_valid && !prev_v) rise_q.push_back(cyc);
        if (last) last_q.push_back(cyc);
        if (bit_valid) vcnt_tot = vcnt_tot + 1;
        if (bit_valid && bit_out) ones_tot = ones_tot + 1;
        if (rand_en) re_tot = re_tot + 1;
        prev_v = bit_valid;

        if (rst) begin
            chk("rst_in_ready",  32'(in_ready),  32'd1);
            chk("rst_rand_en",   32'(rand_en),   32'd0);
            chk("rst_bit_valid", 32'(bit_valid), 32'd0);
            chk("rst_bit_out",   32'(bit_out),   32'd0);
            chk("rst_last",      32'(last),      32'd0);
            chk("rst_ones_cnt",  32'(ones_cnt),  32'd0);
            have_acc = 1'b0;
            last_bit = 1'b0;
            ones_m   = 0;
        end else begin
            d    = cyc - acc_cyc;
            busy = have_acc && (d >= 1) && (d <= 2 + N);
            vexp = have_acc && (d >= 4) && (d <= 3 + N);
            if (vexp) begin
                bexp     = (rhist[(cyc - 1) % 1024][15:0] < op_m);
                last_bit = bexp;
                if (bexp) ones_m = ones_m + 1;
            end
`ifdef SNG_ONES_COUNT_EN
            exp_ones = ones_m;
`else
            exp_ones = 0;
`endif
            chk("in_ready",  32'(in_ready),  32'(!busy));
            chk("rand_en",   32'(rand_en),   32'(busy));
            chk("bit_valid", 32'(bit_valid), 32'(vexp));
            chk("bit_out",   32'(bit_out),   32'(last_bit));
            chk("last",      32'(last),      32'(vexp && (d == 3 + N)));
            chk("ones_cnt",  32'(ones_cnt),  32'(exp_ones));
            if (in_valid && !busy) begin
                have_acc = 1'b1;
                acc_cyc  = cyc;
                op_m     = in_value;
                ones_m   = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, output int a);
        in_valid = 1'b1;
        in_value = v;
        a = cyc;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    function automatic logic [31:0] qget(input int q[$], input int idx);
        if (idx < 0 || idx >= q.size()) return 32'hFFFF_FFFF;
        return 32'(q[idx]);
    endfunction

    int a, b, v0, o0, l0, r0, re0, ref_ones, exp_lit;

    initial begin
        #1;
        chk("init_in_ready",  32'(in_ready),  32'd1);
        chk("init_bit_valid", 32'(bit_valid), 32'd0);
        chk("init_rand_en",   32'(rand_en),   32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // op = 0: all zeros, 16 bits in cycles a+4..a+19
        v0 = vcnt_tot; o0 = ones_tot; l0 = last_q.size(); r0 = rise_q.size();
        send(16'h0000, a);
        wait_until(a + 20);
        chk("op0_nvalid",     32'(vcnt_tot - v0),      32'd16);
        chk("op0_nones",      32'(ones_tot - o0),      32'd0);
        chk("op0_nlast",      32'(last_q.size() - l0), 32'd1);
        chk("op0_last_cyc",   qget(last_q, l0),        32'(a + 19));
        chk("op0_first_cyc",  qget(rise_q, r0),        32'(a + 4));
        chk("op0_ones_cnt",   32'(ones_cnt),           32'd0);

        // Upper rand bits ignored: 0x0100 < 0x0101 every cycle
        rand_fix = 32'hFFFF_0100; rand_mode = 1;
        tick(1);
        v0 = vcnt_tot; o0 = ones_tot;
        send(16'h0101, a);
        wait_until(a + 20);
        chk("hi_nones",  32'(ones_tot - o0), 32'd16);
`ifdef SNG_ONES_COUNT_EN
        exp_lit = 16;
`else
        exp_lit = 0;
`endif
        chk("hi_ones_cnt", 32'(ones_cnt), 32'(exp_lit));

        // No saturation: op=0xFFFF vs rand 0xFFFF gives 0
        rand_fix = 32'h0000_FFFF;
        tick(1);
        v0 = vcnt_tot; o0 = ones_tot;
        send(16'hFFFF, a);
        wait_until(a + 20);
        chk("sat_nvalid",   32'(vcnt_tot - v0), 32'd16);
        chk("sat_nones",    32'(ones_tot - o0), 32'd0);
        chk("sat_ones_cnt", 32'(ones_cnt),      32'd0);
        rand_mode = 0;
        tick(1);

        // in_valid held 40 cycles: accepts at a, a+19, a+38
        r0 = rise_q.size(); l0 = last_q.size();
        in_valid = 1'b1; in_value = 16'h8000; a = cyc;
        tick(1);
        in_value = 16'h0000;
        tick(39);
        in_valid = 1'b0;
        wait_until(a + 38 + 20);
        chk("b2b_first1", qget(rise_q, r0),     32'(a + 4));
        chk("b2b_last1",  qget(last_q, l0),     32'(a + 19));
        chk("b2b_first2", qget(rise_q, r0 + 1), 32'(a + 23));
        chk("b2b_last2",  qget(last_q, l0 + 1), 32'(a + 38));
        chk("b2b_nlast",  32'(last_q.size() - l0), 32'd3);

        // Reset after the 5th bit abandons the stream
        l0 = last_q.size();
        send(16'h8000, a);
        wait_until(a + 9);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_bit_valid", 32'(bit_valid), 32'd0);
        chk("arst_last",      32'(last),      32'd0);
        chk("arst_bit_out",   32'(bit_out),   32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_rand_en",   32'(rand_en),   32'd0);
        tick(1);
        rst = 1'b0;
        v0 = vcnt_tot; re0 = re_tot;
        send(16'h8000, b);
        chk("post_rst_acc", 32'(b), 32'(a + 10));
        wait_until(b + 20);
        chk("abort_nlast",  32'(last_q.size() - l0), 32'd1);
        chk("full_last",    qget(last_q, l0),        32'(b + 19));
        chk("full_nvalid",  32'(vcnt_tot - v0),      32'd16);
        chk("full_rand_en", 32'(re_tot - re0),       32'd18);
        ref_ones = 0;
        for (int k = 3; k <= 18; k++)
            if (rhist[(b + k) % 1024][15:0] < 16'h8000) ref_ones = ref_ones + 1;
`ifdef SNG_ONES_COUNT_EN
        exp_lit = ref_ones;
`else
        exp_lit = 0;
`endif
        chk("full_ones_cnt", 32'(ones_cnt), 32'(exp_lit));

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
